// File: rtl/uart_operand_framer.sv
// Packs UART bytes MSB-first into {opA, opB} frames for the iterative multiplier.
// An inter-byte timeout discards partial frames; discards are counted (saturating).
module uart_operand_framer #(
  parameter int BytesPerFrame  = 8,
  parameter int TimeoutCycles  = 4096,
  parameter int DropCountWidth = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [7:0]                   byte_data_i,
  input  logic                         byte_valid_i,
  output logic                         byte_ready_o,
  output logic [8*BytesPerFrame-1:0]   frame_data_o,
  output logic                         frame_valid_o,
  input  logic                         frame_yumi_i,
  output logic                         drop_pulse_o,
  output logic [DropCountWidth-1:0]    drop_count_o
);

  localparam int CntW = $clog2(BytesPerFrame + 1);
  localparam int TmoW = $clog2(TimeoutCycles);
  localparam int FrW  = 8 * BytesPerFrame;

  typedef enum logic {COLLECT, FULL} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [TmoW-1:0]           tmo_q, tmo_d;
  logic [FrW-1:0]            shreg_q, shreg_d;
  logic                      drop_q, drop_d;
  logic [DropCountWidth-1:0] drops_q, drops_d;
  logic                      accept;

  assign accept = byte_valid_i && (state_q == COLLECT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    shreg_d = shreg_q;
    drops_d = drops_q;
    drop_d  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          // An accept always wins over a timeout firing in the same cycle.
          shreg_d = {shreg_q[FrW-9:0], byte_data_i};
          tmo_d   = '0;
          if (cnt_q == CntW'(BytesPerFrame - 1)) begin
            cnt_d   = CntW'(BytesPerFrame);
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q != '0) begin
          if (tmo_q == TmoW'(TimeoutCycles - 1)) begin
            cnt_d  = '0;
            tmo_d  = '0;
            drop_d = 1'b1;
            if (drops_q != '1) drops_d = drops_q + 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (frame_yumi_i) begin
          cnt_d   = '0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      tmo_q   <= '0;
      shreg_q <= '0;
      drop_q  <= 1'b0;
      drops_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      shreg_q <= shreg_d;
      drop_q  <= drop_d;
      drops_q <= drops_d;
    end
  end

  assign byte_ready_o  = (state_q == COLLECT);
  assign frame_valid_o = (state_q == FULL);
  assign frame_data_o  = shreg_q;
  assign drop_pulse_o  = drop_q;
  assign drop_count_o  = drops_q;

endmodule
